// File: rtl/rx78_pkg.sv
// Shared types and constants for the rx78 EXT RAM upload path.
package rx78_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } rx78_state_t;

  localparam logic [7:0] RX78_UPLOAD_INDEX = 8'd2;
  localparam int         RX78_EXTRAM_BYTES = 16384;

endpackage

// File: rtl/rx78_ram_upload.sv
// Serves HPS upload (read-back) byte reads from the rx78 EXT RAM second port
// and tracks whether EXT RAM has been modified since the last complete upload.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no read outstanding; unselected strobes answer 8'hFF
// REQ   | mem_rd held, ioctl_wait high, waiting for mem_ack or timeout
// DONE  | read data registered; a strobe arriving here is accepted directly
import rx78_pkg::*;

module rx78_ram_upload #(
  parameter int         ADDR_W       = 14,
  parameter int         MEM_BYTES    = RX78_EXTRAM_BYTES,
  parameter logic [7:0] UPLOAD_INDEX = RX78_UPLOAD_INDEX,
  parameter int         TIMEOUT      = 63
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ext_en,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [7:0]        mem_q,
  input  logic              cpu_ram_we,
  output logic              dirty,
  output logic              busy,
  output logic              timeout_err
);

  rx78_state_t state;
  logic [5:0]  timer;
  logic        upload_q;
  logic        last_seen;

  logic index_hit;
  logic addr_in_range;
  logic sel_rd;
  logic up_rise;
  logic up_fall;
  logic tmo_hit;
  logic at_last_addr;

  assign index_hit     = (ioctl_index == UPLOAD_INDEX);
  assign addr_in_range = (ioctl_addr < 25'(MEM_BYTES));
  assign sel_rd        = ioctl_rd && ioctl_upload && index_hit && ext_en && addr_in_range;
  assign up_rise       = ioctl_upload && !upload_q && index_hit;
  assign up_fall       = !ioctl_upload && upload_q;
  // timer starts at 0 on entry to REQ, so hitting TIMEOUT-1 here means
  // ioctl_wait has been high for exactly TIMEOUT cycles
  assign tmo_hit       = (timer == 6'(TIMEOUT - 1));
  assign at_last_addr  = (mem_addr == ADDR_W'(MEM_BYTES - 1));

  // Read-handshake FSM with registered outputs, session error and last-address tracking
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ioctl_din   <= 8'hFF;
      ioctl_wait  <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      busy        <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
      last_seen   <= 1'b0;
    end else begin
      if (up_rise) begin
        timeout_err <= 1'b0;
        last_seen   <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (sel_rd) begin
            mem_addr   <= ioctl_addr[ADDR_W-1:0];
            mem_rd     <= 1'b1;
            ioctl_wait <= 1'b1;
            timer      <= '0;
            busy       <= 1'b1;
            state      <= REQ;
          end else begin
            if (ioctl_rd) ioctl_din <= 8'hFF;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        REQ: begin
          // a dropped session wins over a same-cycle ack: the host is gone
          if (!ioctl_upload) begin
            mem_rd     <= 1'b0;
            ioctl_wait <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (mem_ack) begin
            ioctl_din  <= mem_q;
            mem_rd     <= 1'b0;
            ioctl_wait <= 1'b0;
            state      <= DONE;
            if (at_last_addr) last_seen <= 1'b1;
          end else if (tmo_hit) begin
            ioctl_din   <= 8'hFF;
            timeout_err <= 1'b1;
            mem_rd      <= 1'b0;
            ioctl_wait  <= 1'b0;
            state       <= DONE;
          end else if (timer != 6'h3F) begin
            timer <= timer + 6'd1;
          end
        end
        default: begin
          mem_rd     <= 1'b0;
          ioctl_wait <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Session edge detect and dirty flag; a CPU write beats a same-cycle clear
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      upload_q <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (cpu_ram_we)
        dirty <= 1'b1;
      else if (up_fall && last_seen && !timeout_err)
        dirty <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx78_ram_upload.sv
// Self-checking bench for rx78_ram_upload: a transaction-level model of the
// upload responder is compared against the DUT after every clock edge, with
// literal expectations at the interesting points of each scenario.
module tb_rx78_ram_upload;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ext_en;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_q;
  logic        cpu_ram_we;
  logic        dirty;
  logic        busy;
  logic        timeout_err;

  rx78_ram_upload dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ext_en       (ext_en),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ack      (mem_ack),
    .mem_q        (mem_q),
    .cpu_ram_we   (cpu_ram_we),
    .dirty        (dirty),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level reference: one outstanding read at most, described by
  // "pending" (waiting for the memory) and "finishing" (data just returned).
  // ---------------------------------------------------------------------
  logic [7:0]  m_din      = 8'hFF;
  logic        m_pend     = 1'b0;
  logic        m_finish   = 1'b0;
  logic [13:0] m_addr     = '0;
  int          m_age      = 0;
  logic        m_dirty    = 1'b0;
  logic        m_terr     = 1'b0;
  logic        m_last     = 1'b0;
  logic        m_up_prev  = 1'b0;
  logic        m_rise, m_fall, m_sel;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_din = 8'hFF; m_pend = 0; m_finish = 0; m_addr = '0; m_age = 0;
      m_dirty = 0; m_terr = 0; m_last = 0; m_up_prev = 0;
    end else begin
      m_fall = !ioctl_upload && m_up_prev;
      m_rise = ioctl_upload && !m_up_prev && (ioctl_index == 8'd2);
      if (cpu_ram_we) m_dirty = 1;
      else if (m_fall && m_last && !m_terr) m_dirty = 0;
      if (m_rise) begin m_terr = 0; m_last = 0; end
      if (m_pend) begin
        if (!ioctl_upload) begin
          m_pend = 0; m_finish = 0;
        end else if (mem_ack) begin
          m_din = mem_q;
          if (m_addr == 14'h3FFF) m_last = 1;
          m_pend = 0; m_finish = 1;
        end else begin
          m_age = m_age + 1;
          if (m_age == 63) begin
            m_din = 8'hFF; m_terr = 1; m_pend = 0; m_finish = 1;
          end
        end
      end else begin
        m_finish = 0;
        if (ioctl_rd) begin
          m_sel = ioctl_upload && (ioctl_index == 8'd2) && ext_en && (ioctl_addr < 25'd16384);
          if (m_sel) begin
            m_pend = 1; m_addr = ioctl_addr[13:0]; m_age = 0;
          end else begin
            m_din = 8'hFF;
          end
        end
      end
      m_up_prev = ioctl_upload;
    end
  end

  // Compare every output against the model shortly after each active edge
  always @(posedge clk_sys) begin
    #1;
    if (reset_n) begin
      chk("cyc_din",   ioctl_din,   m_din);
      chk("cyc_wait",  ioctl_wait,  m_pend);
      chk("cyc_memrd", mem_rd,      m_pend);
      chk("cyc_maddr", mem_addr,    m_addr);
      chk("cyc_busy",  busy,        m_pend | m_finish);
      chk("cyc_dirty", dirty,       m_dirty);
      chk("cyc_terr",  timeout_err, m_terr);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (all driven from negedges)
  // ---------------------------------------------------------------------
  // Selected read answered by the memory after lat cycles; RAM holds a[7:0] at a.
  task automatic read_tx(input logic [24:0] a, input int lat, input bit viol);
    ioctl_rd = 1; ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 0; cpu_ram_we = 0;
    for (int k = 1; k < lat; k++) begin
      if (viol && $urandom_range(0, 3) == 0) begin
        ioctl_rd = 1; ioctl_addr = 25'($urandom);
      end
      @(negedge clk_sys);
      ioctl_rd = 0;
    end
    mem_ack = 1; mem_q = mem_addr[7:0];
    @(negedge clk_sys);
    mem_ack = 0; mem_q = 8'($urandom);
    chk("rd_din", ioctl_din, {24'd0, a[7:0]});
    chk("rd_wait_low", ioctl_wait, 0);
  endtask

  // Read that must not be selected: 8'hFF next edge, no handshake.
  task automatic unsel_rd(input logic [24:0] a);
    ioctl_rd = 1; ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 0;
    chk("unsel_din", ioctl_din, 8'hFF);
    chk("unsel_wait", ioctl_wait, 0);
    chk("unsel_memrd", mem_rd, 0);
    chk("unsel_busy", busy, 0);
  endtask

  int cnt;
  int guard;
  int lat;

  initial begin
    ext_en = 1; ioctl_upload = 0; ioctl_index = 8'd2; ioctl_rd = 0; ioctl_addr = '0;
    mem_ack = 0; mem_q = 8'h00; cpu_ram_we = 0;
    repeat (3) @(negedge clk_sys);
    chk("rst_din", ioctl_din, 8'hFF);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_memrd", mem_rd, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    reset_n = 1;
    @(negedge clk_sys);

    // EXT RAM disabled and out-of-slot / out-of-range reads
    ioctl_upload = 1;
    @(negedge clk_sys);
    read_tx(25'h10, 1, 0);
    ext_en = 0;
    unsel_rd(25'h10);
    ext_en = 1;
    read_tx(25'h21, 2, 0);
    unsel_rd(25'h4000);
    read_tx(25'h22, 1, 0);
    ioctl_index = 8'd1;
    unsel_rd(25'h30);
    ioctl_index = 8'd2;
    read_tx(25'h23, 5, 0);
    unsel_rd(25'h1004005);

    // Timeout after a complete last-address read: dirty must survive the drop
    cpu_ram_we = 1;
    @(negedge clk_sys);
    cpu_ram_we = 0;
    chk("we_dirty", dirty, 1);
    read_tx(25'h3FFF, 3, 0);
    ioctl_rd = 1; ioctl_addr = 25'h55;
    @(negedge clk_sys);
    ioctl_rd = 0;
    cnt = 0; guard = 0;
    while (ioctl_wait && guard < 200) begin
      cnt++; guard++;
      @(negedge clk_sys);
    end
    chk("tmo_wait_cycles", cnt, 63);
    chk("tmo_din", ioctl_din, 8'hFF);
    chk("tmo_err", timeout_err, 1);
    ioctl_upload = 0;
    repeat (2) @(negedge clk_sys);
    chk("tmo_dirty_kept", dirty, 1);

    // Dirty clear on a clean complete upload, and write-wins on the drop edge
    ioctl_upload = 1;
    @(negedge clk_sys);
    chk("rise_terr_clr", timeout_err, 0);
    read_tx(25'h3FFF, 1, 0);
    chk("pre_drop_dirty", dirty, 1);
    ioctl_upload = 0;
    @(negedge clk_sys);
    chk("clean_drop_dirty", dirty, 0);
    ioctl_upload = 1;
    @(negedge clk_sys);
    read_tx(25'h3FFF, 2, 0);
    ioctl_upload = 0; cpu_ram_we = 1;
    @(negedge clk_sys);
    cpu_ram_we = 0;
    chk("we_on_drop_dirty", dirty, 1);
    ioctl_upload = 1;
    @(negedge clk_sys);
    read_tx(25'h100, 1, 0);
    ioctl_upload = 0;
    @(negedge clk_sys);
    chk("partial_dirty", dirty, 1);

    // Session dropped mid-request
    ioctl_upload = 1;
    @(negedge clk_sys);
    read_tx(25'h40, 1, 0);
    ioctl_rd = 1; ioctl_addr = 25'h41;
    @(negedge clk_sys);
    ioctl_rd = 0;
    repeat (2) @(negedge clk_sys);
    chk("req_wait", ioctl_wait, 1);
    ioctl_upload = 0;
    @(negedge clk_sys);
    chk("abort_memrd", mem_rd, 0);
    chk("abort_wait", ioctl_wait, 0);
    chk("abort_busy", busy, 0);
    chk("abort_din", ioctl_din, 8'h40);
    chk("abort_terr", timeout_err, 0);
    ioctl_upload = 1;
    @(negedge clk_sys);
    read_tx(25'h41, 4, 0);

    // Asynchronous reset mid-request, with a stale ack after release
    ioctl_rd = 1; ioctl_addr = 25'h42;
    @(negedge clk_sys);
    ioctl_rd = 0;
    @(negedge clk_sys);
    #2 reset_n = 0;
    #1;
    chk("arst_memrd", mem_rd, 0);
    chk("arst_wait", ioctl_wait, 0);
    chk("arst_busy", busy, 0);
    chk("arst_din", ioctl_din, 8'hFF);
    chk("arst_maddr", mem_addr, 0);
    @(negedge clk_sys);
    reset_n = 1; mem_ack = 1; mem_q = 8'h5A;
    @(negedge clk_sys);
    mem_ack = 0;
    chk("stale_ack_busy", busy, 0);
    chk("stale_ack_din", ioctl_din, 8'hFF);
    read_tx(25'h42, 1, 0);

    // Full image sweep with random ack latency, CPU writes and stray strobes
    ioctl_upload = 0;
    @(negedge clk_sys);
    ioctl_upload = 1;
    @(negedge clk_sys);
    for (int a = 0; a < 16384; a++) begin
      if ($urandom_range(0, 7) == 0) @(negedge clk_sys);
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 1;
      cpu_ram_we = ($urandom_range(0, 499) == 0);
      read_tx(25'(a), lat, $urandom_range(0, 15) == 0);
    end
    cpu_ram_we = 0;
    ioctl_upload = 0;
    @(negedge clk_sys);
    chk("sweep_dirty", dirty, 0);
    chk("sweep_terr", timeout_err, 0);
    repeat (2) @(negedge clk_sys);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
